fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch and memory-port owner for the 8-bit computer. Sits directly upstream of the 256x8 main memory and drives its address, data_in and write_enable.
- Memory timing: it samples address at posedge and presents data_out after that edge; it writes at negedge while write_enable is high.
- Function: holds the program counter, fetches 1- or 2-byte instructions, hands them to the decoder via valid/ready, and arbitrates single-byte data loads and stores from the execute stage.

Parameters:
- ADDR_W, 8, address width; the PC wraps modulo 2^ADDR_W.
- DATA_W, 8, memory word width.
- OPR_BIT, 7, opcode bit that, when 1, marks a 2-byte instruction (opcode followed by an operand byte).
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  system clock, rising-edge logic.
- rst_n  in  1  asynchronous active-low reset.
- mem_addr  out  ADDR_W  to memory address; registered.
- mem_wdata  out  DATA_W  to memory data_in; registered.
- mem_we  out  1  to memory write_enable; registered.
- mem_rdata  in  DATA_W  from memory data_out.
- instr_valid  out  1  instruction held for decoder.
- instr_ready  in  1  decoder accepts.
- instr_opcode  out  DATA_W  opcode byte.
- instr_operand  out  DATA_W  operand byte; 0 for 1-byte instructions.
- instr_pc  out  ADDR_W  address of the opcode.
- jmp_valid  in  1  one-cycle redirect request.
- jmp_addr  in  ADDR_W  redirect target.
- halt  in  1  level; blocks new fetches.
- dreq  in  1  data access request; held until dack.
- dwe  in  1  1 = store, 0 = load.
- daddr  in  ADDR_W  data address.
- dwdata  in  DATA_W  store data.
- dack  out  1  one-cycle completion pulse.
- drdata  out  DATA_W  load result; valid with dack and held afterwards.

Behaviour:
- Reset (async, rst_n low): state=S_IDLE, pc=RESET_PC, mem_addr=0, mem_wdata=0, mem_we=0, instr_valid=0, instr_opcode=0, instr_operand=0, instr_pc=0, dack=0, drdata=0, jmp_pend=0. Reset mid-access aborts it; memory contents are untouched except by a write whose negedge has already occurred.
- Read access, 3 cycles:
  - A: mem_addr<=addr at the end of A.
  - W: memory samples at the end of W.
  - C: mem_rdata is valid; capture at the end of C.
- States: S_IDLE, S_OP_A/W/C, S_OPR_A/W/C, S_HOLD, S_DR_A/W/C, S_DW.
- S_IDLE:
  - dreq has priority: go S_DR_A if dwe=0, else S_DW.
  - Otherwise, if !halt, go S_OP_A.
- S_OP_C: capture opcode and instr_pc=pc; pc<=pc+1.
  - opcode[OPR_BIT]=1: go S_OPR_A.
  - opcode[OPR_BIT]=0: operand=0, instr_valid<=1, go S_HOLD.
- S_OPR_C: capture operand, pc<=pc+1, instr_valid<=1, go S_HOLD.
- S_HOLD: outputs stable while instr_valid=1 and !instr_ready. On instr_ready: instr_valid<=0, go S_IDLE.
- Best-case throughput: 1-byte instruction every 5 cycles (A, W, C, HOLD with ready=1, IDLE); 2-byte instruction every 8 cycles.
- Data load: S_DR_A/W/C use mem_addr=daddr. At the end of S_DR_C: drdata<=mem_rdata, dack<=1, go S_IDLE.
- Data store (S_DW): mem_addr<=daddr, mem_wdata<=dwdata, mem_we<=1 for exactly one cycle, so the memory writes at that cycle's negedge. Next cycle: mem_we<=0, dack<=1, go S_IDLE.
- dreq is re-sampled only in S_IDLE, so an in-flight instruction fetch is never interrupted by a data access.
- Jump:
  - In fetch states or S_HOLD: pc<=jmp_addr, instr_valid<=0, discard partial fetch, go S_IDLE.
  - jmp_valid together with instr_ready in S_HOLD: the instruction counts as accepted, then the jump applies.
  - In S_DR_*/S_DW: jmp_pend latches jmp_addr; the access completes; then pc<=pending target.
  - A later jump overwrites the pending one.
- halt: sampled only in S_IDLE. A held instruction stays presented while halted; dreq is still served.
- Wrap-around: pc 255+1=0. A 2-byte instruction at 255 takes its operand from address 0.

Decomposition:
- Shared package cpu_pkg:
  - ADDR_W and DATA_W constants.
  - fetch_state_t enum.
  - addr_t and byte_t typedefs.
  - OPR_BIT constant, shared with the decoder.
- No sub-module: one FSM with datapath registers.

Test Plan:
- Reset, mem[0]=0x05 (1-byte), instr_ready=1 -> mem_addr=0 registered at the end of S_OP_A; instr_valid rises with opcode=0x05, operand=0, instr_pc=0; the next fetch uses mem_addr=1.
- mem[2]=0x83, mem[3]=0x7F, pc=2 -> instr_opcode=0x83, instr_operand=0x7F, instr_pc=2, pc=4; 8 cycles from S_OP_A to S_IDLE with ready=1.
- instr_ready=0 for 10 cycles -> opcode, operand, instr_pc and instr_valid stable; no memory address change.
- Store: dreq=1, dwe=1, daddr=0x10, dwdata=0xAA during S_IDLE -> mem_we high for one cycle with mem_addr=0x10; dack next cycle. A following load of 0x10 returns drdata=0xAA with dack.
- jmp_valid with jmp_addr=0x40 during S_OPR_W -> instr_valid stays 0; the next opcode is fetched from 0x40. A jump during S_DR_W: the load completes with dack, then the fetch starts at the target.
- pc=255, mem[255]=0x90, mem[0]=0x11 -> operand=0x11 and pc wraps to 1. rst_n pulsed low mid-S_DW -> all outputs reset immediately, mem_we=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, byte/address types and fetch FSM states for the 8-bit CPU
package cpu_pkg;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int OPR_BIT = 7;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] byte_t;
    typedef enum logic [3:0] {
        S_IDLE,
        S_OP_A, S_OP_W, S_OP_C,
        S_OPR_A, S_OPR_W, S_OPR_C,
        S_HOLD,
        S_DR_A, S_DR_W, S_DR_C,
        S_DW
    } fetch_state_t;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, instruction fetcher and data-port arbiter in front of main memory
module fetch_unit #(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int OPR_BIT = cpu_pkg::OPR_BIT,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_opcode,
    output logic [DATA_W-1:0] instr_operand,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              jmp_valid,
    input  logic [ADDR_W-1:0] jmp_addr,
    input  logic              halt,
    input  logic              dreq,
    input  logic              dwe,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dwdata,
    output logic              dack,
    output logic [DATA_W-1:0] drdata
);
    import cpu_pkg::*;

    fetch_state_t      state, state_n;
    logic [ADDR_W-1:0] pc, pc_n, addr_n, ipc_n, tgt_n, jmp_tgt;
    logic [DATA_W-1:0] wdata_n, op_n, opr_n, rd_n;
    logic              we_n, valid_n, dack_n, pend_n, jmp_pend;
    logic              fetching, data_busy, data_done;

    assign fetching  = state inside {S_OP_A, S_OP_W, S_OP_C, S_OPR_A, S_OPR_W, S_OPR_C, S_HOLD};
    assign data_busy = state inside {S_DR_A, S_DR_W, S_DR_C, S_DW};
    assign data_done = state == S_DR_C || state == S_DW;

    always_comb begin
        state_n = state;
        pc_n    = pc;
        addr_n  = mem_addr;
        wdata_n = mem_wdata;
        we_n    = 1'b0;
        valid_n = instr_valid;
        op_n    = instr_opcode;
        opr_n   = instr_operand;
        ipc_n   = instr_pc;
        dack_n  = 1'b0;
        rd_n    = drdata;
        pend_n  = jmp_pend;
        tgt_n   = jmp_tgt;
        case (state)
            S_IDLE: begin
                pc_n = jmp_valid ? jmp_addr : pc;
                if (dreq) begin
                    state_n = dwe ? S_DW : S_DR_A;
                    addr_n  = dwe ? daddr : mem_addr;
                    wdata_n = dwe ? dwdata : mem_wdata;
                    we_n    = dwe;
                end else if (!halt) begin
                    state_n = S_OP_A;
                end
            end
            S_OP_A: begin
                addr_n  = pc;
                state_n = S_OP_W;
            end
            S_OP_W: state_n = S_OP_C;
            S_OP_C: begin
                op_n    = mem_rdata;
                ipc_n   = pc;
                pc_n    = pc + 1'b1;
                opr_n   = '0;
                valid_n = !mem_rdata[OPR_BIT];
                state_n = mem_rdata[OPR_BIT] ? S_OPR_A : S_HOLD;
            end
            S_OPR_A: begin
                addr_n  = pc;
                state_n = S_OPR_W;
            end
            S_OPR_W: state_n = S_OPR_C;
            S_OPR_C: begin
                opr_n   = mem_rdata;
                pc_n    = pc + 1'b1;
                valid_n = 1'b1;
                state_n = S_HOLD;
            end
            S_HOLD: begin
                valid_n = !instr_ready;
                state_n = instr_ready ? S_IDLE : S_HOLD;
            end
            S_DR_A: begin
                addr_n  = daddr;
                state_n = S_DR_W;
            end
            S_DR_W: state_n = S_DR_C;
            S_DR_C: begin
                rd_n    = mem_rdata;
                dack_n  = 1'b1;
                state_n = S_IDLE;
            end
            S_DW: begin
                dack_n  = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        // A redirect abandons any fetch or held instruction outright
        if (jmp_valid && fetching) begin
            pc_n    = jmp_addr;
            valid_n = 1'b0;
            state_n = S_IDLE;
        end
        // Data accesses are never cut short; the redirect waits for completion
        if (jmp_valid && data_busy) begin
            pend_n = 1'b1;
            tgt_n  = jmp_addr;
        end
        if (data_done) begin
            pc_n   = jmp_valid ? jmp_addr : jmp_pend ? jmp_tgt : pc;
            pend_n = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            pc            <= RESET_PC;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_we        <= 1'b0;
            instr_valid   <= 1'b0;
            instr_opcode  <= '0;
            instr_operand <= '0;
            instr_pc      <= '0;
            dack          <= 1'b0;
            drdata        <= '0;
            jmp_pend      <= 1'b0;
            jmp_tgt       <= '0;
        end else begin
            state         <= state_n;
            pc            <= pc_n;
            mem_addr      <= addr_n;
            mem_wdata     <= wdata_n;
            mem_we        <= we_n;
            instr_valid   <= valid_n;
            instr_opcode  <= op_n;
            instr_operand <= opr_n;
            instr_pc      <= ipc_n;
            dack          <= dack_n;
            drdata        <= rd_n;
            jmp_pend      <= pend_n;
            jmp_tgt       <= tgt_n;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random checks of fetch_unit against a memory image and instruction-stream model
module tb_fetch_unit;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_we;
    logic       instr_valid, instr_ready;
    logic [7:0] instr_opcode, instr_operand, instr_pc;
    logic       jmp_valid;
    logic [7:0] jmp_addr;
    logic       halt, dreq, dwe;
    logic [7:0] daddr, dwdata;
    logic       dack;
    logic [7:0] drdata;

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    int n_assert = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_opcode(instr_opcode),
        .instr_operand(instr_operand), .instr_pc(instr_pc),
        .jmp_valid(jmp_valid), .jmp_addr(jmp_addr), .halt(halt),
        .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata), .dack(dack), .drdata(drdata)
    );

    always @(posedge clk) mem_rdata <= mem[mem_addr];
    always @(negedge clk) if (mem_we) mem[mem_addr] = mem_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max, output int cyc);
        cyc = 0;
        while (!instr_valid && cyc < max) begin
            tick;
            cyc++;
        end
        chk("valid_wait", 32'(instr_valid), 1);
    endtask

    function automatic logic [7:0] instr_len(input logic [7:0] p);
        return ref_mem[p][7] ? 8'd2 : 8'd1;
    endfunction

    task automatic expect_instr(input string tag, input logic [7:0] p);
        logic [7:0] op;
        op = ref_mem[p];
        chk({tag, "_op"}, 32'(instr_opcode), 32'(op));
        chk({tag, "_opr"}, 32'(instr_operand), op[7] ? 32'(ref_mem[p + 8'd1]) : 0);
        chk({tag, "_pc"}, 32'(instr_pc), 32'(p));
    endtask

    initial begin
        int cyc, accepts, wait_c;
        logic [7:0] mpc, hold_addr;
        logic [24:0] held;
        rst_n = 1'b1; instr_ready = 1'b0; jmp_valid = 1'b0; jmp_addr = '0;
        halt = 1'b1; dreq = 1'b0; dwe = 1'b0; daddr = '0; dwdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h05; mem[1] = 8'h22; mem[2] = 8'h83; mem[3] = 8'h7F;
        mem[4] = 8'h12; mem[5] = 8'h9A; mem[6] = 8'h01; mem[8'h10] = 8'h00;
        mem[8'h40] = 8'h33; mem[8'h80] = 8'h44; mem[8'hFF] = 8'h90;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];

        #1 rst_n = 1'b0;
        #2;
        chk("rst_ctl", 32'({mem_we, instr_valid, dack}), 0);
        chk("rst_mem", 32'({mem_addr, mem_wdata}), 0);
        chk("rst_instr", 32'({instr_opcode, instr_operand, instr_pc}), 0);
        chk("rst_drdata", 32'(drdata), 0);
        tick; tick;
        rst_n = 1'b1; halt = 1'b0; instr_ready = 1'b1;

        tick; tick;
        chk("op_a_addr", 32'(mem_addr), 0);
        chk("op_a_valid", 32'(instr_valid), 0);
        tick; tick;
        chk("first_valid", 32'(instr_valid), 1);
        expect_instr("first", 8'h00);
        tick;
        chk("accept_drop", 32'(instr_valid), 0);
        tick; tick;
        chk("next_addr", 32'(mem_addr), 1);
        wait_valid(10, cyc);
        chk("one_byte_period", 32'(3 + cyc), 5);
        expect_instr("second", 8'h01);
        tick;
        wait_valid(12, cyc);
        chk("two_byte_period", 32'(1 + cyc), 8);
        expect_instr("two_byte", 8'h02);
        tick; tick; tick;
        chk("pc_after_2b", 32'(mem_addr), 4);

        instr_ready = 1'b0;
        wait_valid(10, cyc);
        expect_instr("stall", 8'h04);
        held = {instr_valid, instr_opcode, instr_operand, instr_pc};
        hold_addr = mem_addr;
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("stall_outputs", 32'({instr_valid, instr_opcode, instr_operand, instr_pc}), 32'({1'b1, 8'h12, 8'h00, 8'h04}));
            chk("stall_addr", 32'(mem_addr), 32'(hold_addr));
        end
        chk("stall_snapshot", 32'(held), 32'({1'b1, 8'h12, 8'h00, 8'h04}));
        instr_ready = 1'b1; halt = 1'b1;
        tick;
        chk("stall_release", 32'(instr_valid), 0);

        dreq = 1'b1; dwe = 1'b1; daddr = 8'h10; dwdata = 8'hAA;
        tick;
        chk("store_we", 32'({mem_we, mem_addr, dack}), 32'({1'b1, 8'h10, 1'b0}));
        tick;
        chk("store_done", 32'({mem_we, dack}), 32'({1'b0, 1'b1}));
        dreq = 1'b0;
        ref_mem[8'h10] = 8'hAA;
        chk("store_mem", 32'(mem[8'h10]), 32'(ref_mem[8'h10]));
        tick;
        chk("dack_pulse", 32'(dack), 0);
        dreq = 1'b1; dwe = 1'b0; daddr = 8'h10;
        cyc = 0;
        while (!dack && cyc < 10) begin
            tick;
            cyc++;
        end
        chk("load_latency", 32'(cyc), 4);
        chk("load_data", 32'(drdata), 32'(ref_mem[8'h10]));
        dreq = 1'b0;
        tick;
        chk("load_held", 32'({dack, drdata}), 32'({1'b0, 8'hAA}));

        halt = 1'b0;
        for (int i = 0; i < 5; i++) tick;
        chk("opr_w_addr", 32'(mem_addr), 6);
        jmp_valid = 1'b1; jmp_addr = 8'h40;
        tick;
        jmp_valid = 1'b0;
        chk("jmp_fetch_valid", 32'(instr_valid), 0);
        tick;
        chk("jmp_fetch_valid2", 32'(instr_valid), 0);
        tick;
        chk("jmp_target_addr", 32'(mem_addr), 32'h40);
        wait_valid(10, cyc);
        expect_instr("jmp_target", 8'h40);
        tick;

        dreq = 1'b1; dwe = 1'b0; daddr = 8'h10; halt = 1'b1;
        tick; tick;
        chk("dr_w_addr", 32'(mem_addr), 32'h10);
        jmp_valid = 1'b1; jmp_addr = 8'h80;
        tick;
        jmp_valid = 1'b0;
        chk("dr_jmp_nodack", 32'(dack), 0);
        tick;
        chk("dr_jmp_dack", 32'({dack, drdata}), 32'({1'b1, 8'hAA}));
        dreq = 1'b0; halt = 1'b0;
        tick; tick;
        chk("dr_jmp_addr", 32'(mem_addr), 32'h80);
        wait_valid(10, cyc);
        expect_instr("dr_jmp_target", 8'h80);

        mem[0] = 8'h11; ref_mem[0] = 8'h11;
        jmp_valid = 1'b1; jmp_addr = 8'hFF;
        tick;
        jmp_valid = 1'b0;
        chk("hold_jmp_valid", 32'(instr_valid), 0);
        wait_valid(12, cyc);
        expect_instr("wrap", 8'hFF);
        tick; tick; tick;
        chk("wrap_pc", 32'(mem_addr), 1);

        mpc = 8'h01; accepts = 0; wait_c = 0;
        for (int c = 0; c < 800; c++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            halt = ($urandom_range(0, 7) == 0);
            if (instr_valid && instr_ready) begin
                expect_instr("rand", mpc);
                mpc = mpc + instr_len(mpc);
                accepts++;
            end
            if (dreq) begin
                if (dack) begin
                    if (dwe) ref_mem[daddr] = dwdata;
                    else chk("rand_load", 32'(drdata), 32'(ref_mem[daddr]));
                    dreq = 1'b0;
                end else if (++wait_c > 40) begin
                    chk("rand_dack_timeout", 32'(dack), 1);
                    dreq = 1'b0;
                end
            end else if ($urandom_range(0, 9) == 0) begin
                dreq = 1'b1; dwe = 1'($urandom); daddr = 8'($urandom); dwdata = 8'($urandom);
                wait_c = 0;
            end
            tick;
        end
        chk("rand_progress", 32'(accepts > 20), 1);

        dreq = 1'b0; halt = 1'b1; instr_ready = 1'b1;
        for (int i = 0; i < 12; i++) tick;
        dreq = 1'b1; dwe = 1'b1; daddr = 8'h20; dwdata = ~ref_mem[8'h20];
        tick;
        chk("dw_we", 32'({mem_we, mem_addr}), 32'({1'b1, 8'h20}));
        rst_n = 1'b0;
        #1;
        chk("rst_mid_dw_ctl", 32'({mem_we, instr_valid, dack}), 0);
        chk("rst_mid_dw_mem", 32'({mem_addr, mem_wdata}), 0);
        chk("rst_mid_dw_drdata", 32'(drdata), 0);
        @(negedge clk);
        #1;
        chk("rst_mid_dw_nowrite", 32'(mem[8'h20]), 32'(ref_mem[8'h20]));
        dreq = 1'b0; halt = 1'b0;
        tick;
        rst_n = 1'b1;
        tick; tick;
        chk("reset_pc", 32'(mem_addr), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
